// File: rtl/des_block_packer.sv
// Packs a valid/ready byte stream MSB-first into 64-bit DES plaintext blocks,
// padding the final partial block and holding each block in a one-entry output register.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_EMPTY   | no block held, out_valid=0
// ST_PRESENT | out_block/out_last/out_nbytes hold a block, out_valid=1
module des_block_packer #(
    parameter logic [7:0] PAD_BYTE = 8'hFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_block,
    output logic        out_last,
    output logic [3:0]  out_nbytes,
    output logic [31:0] blk_count
);

    localparam logic [0:0] ST_EMPTY   = 1'b0;
    localparam logic [0:0] ST_PRESENT = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [55:0] acc_q, acc_d;
    logic [63:0] out_block_q, out_block_d;
    logic        out_last_q, out_last_d;
    logic [3:0]  out_nbytes_q, out_nbytes_d;
    logic [31:0] blk_count_q, blk_count_d;

    logic        in_fire;
    logic        out_fire;
    logic        blk_done;
    logic [63:0] acc_ext;
    logic [63:0] new_block;

    // rst_n gates in_ready so nothing is accepted while reset is held
    assign in_ready   = rst_n && ((state_q == ST_EMPTY) || out_ready);
    assign out_valid  = (state_q == ST_PRESENT);
    assign out_block  = out_block_q;
    assign out_last   = out_last_q;
    assign out_nbytes = out_nbytes_q;
    assign blk_count  = blk_count_q;

    always_comb begin
        in_fire  = in_valid && in_ready;
        out_fire = (state_q == ST_PRESENT) && out_ready;
        blk_done = in_fire && ((idx_q == 3'd7) || in_last);
        acc_ext  = {acc_q, 8'h00};

        new_block = '0;
        for (int i = 0; i < 8; i++) begin
            if (3'(i) < idx_q) begin
                new_block[63-8*i -: 8] = acc_ext[63-8*i -: 8];
            end else if (3'(i) == idx_q) begin
                new_block[63-8*i -: 8] = in_data;
            end else begin
                new_block[63-8*i -: 8] = PAD_BYTE;
            end
        end

        state_d      = state_q;
        idx_d        = idx_q;
        acc_d        = acc_q;
        out_block_d  = out_block_q;
        out_last_d   = out_last_q;
        out_nbytes_d = out_nbytes_q;
        blk_count_d  = blk_count_q;

        if (out_fire) begin
            blk_count_d = blk_count_q + 32'd1;
            state_d     = ST_EMPTY;
        end

        // A completing byte overrides the drain above, giving back-to-back blocks
        if (blk_done) begin
            state_d      = ST_PRESENT;
            idx_d        = 3'd0;
            acc_d        = '0;
            out_block_d  = new_block;
            out_last_d   = in_last;
            out_nbytes_d = {1'b0, idx_q} + 4'd1;
        end else if (in_fire) begin
            idx_d = idx_q + 3'd1;
            for (int i = 0; i < 7; i++) begin
                if (3'(i) == idx_q) begin
                    acc_d[55-8*i -: 8] = in_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            idx_q        <= 3'd0;
            acc_q        <= '0;
            out_block_q  <= '0;
            out_last_q   <= 1'b0;
            out_nbytes_q <= 4'd0;
            blk_count_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            out_block_q  <= out_block_d;
            out_last_q   <= out_last_d;
            out_nbytes_q <= out_nbytes_d;
            blk_count_q  <= blk_count_d;
        end
    end

endmodule

// File: tb/tb_des_block_packer.sv
// Bench for des_block_packer: vector table plus hand-written sequences, with a
// scoreboard queue of expected blocks checked at every output handshake.
module tb_des_block_packer;

    typedef struct packed {
        logic [63:0] blk;
        logic        last;
        logic [3:0]  nb;
    } exp_t;

    typedef struct {
        int          n;
        logic [7:0]  start;
        logic [7:0]  step;
        logic        last;
        logic [63:0] blk;
        logic [3:0]  nb;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_block;
    logic        out_last;
    logic [3:0]  out_nbytes;
    logic [31:0] blk_count;

    logic        p_in_valid = 1'b0;
    logic        p_in_ready;
    logic [7:0]  p_in_data = 8'h00;
    logic        p_in_last = 1'b0;
    logic        p_out_valid;
    logic        p_out_ready = 1'b1;
    logic [63:0] p_out_block;
    logic        p_out_last;
    logic [3:0]  p_out_nbytes;
    logic [31:0] p_blk_count;

    int checks = 0;
    int failures = 0;
    int hs_count = 0;
    int blocks_sent = 0;
    exp_t sbq[$];
    vec_t vt[7];

    logic stream_mon = 1'b0;
    int   s_cyc = 0;
    int   s_last_ov = -1;
    int   s_ov_cnt = 0;
    int   s_gap_err = 0;
    int   s_ir_low = 0;

    always #5 clk = ~clk;

    des_block_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_block  (out_block),
        .out_last   (out_last),
        .out_nbytes (out_nbytes),
        .blk_count  (blk_count)
    );

    des_block_packer #(.PAD_BYTE(8'h5A)) dut_pad (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (p_in_valid),
        .in_ready   (p_in_ready),
        .in_data    (p_in_data),
        .in_last    (p_in_last),
        .out_valid  (p_out_valid),
        .out_ready  (p_out_ready),
        .out_block  (p_out_block),
        .out_last   (p_out_last),
        .out_nbytes (p_out_nbytes),
        .blk_count  (p_blk_count)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input logic [63:0] blk, input logic last, input logic [3:0] nb);
        exp_t e;
        e.blk  = blk;
        e.last = last;
        e.nb   = nb;
        sbq.push_back(e);
        blocks_sent++;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send_byte(input logic [7:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=in_ready_low required=in_ready_high");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (sbq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", sbq.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Output monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hs_count = 0;
            end else begin
                if (stream_mon) begin
                    s_cyc++;
                    if (!in_ready) s_ir_low++;
                    if (out_valid) begin
                        s_ov_cnt++;
                        if (s_last_ov >= 0 && (s_cyc - s_last_ov) != 8) s_gap_err++;
                        s_last_ov = s_cyc;
                    end
                end
                if (out_valid && out_ready) begin
                    chk("blk_count_at_hs", 64'(blk_count), 64'(hs_count));
                    if (sbq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_block actual=%h required=none", out_block);
                    end else begin
                        e = sbq.pop_front();
                        chk("sb_block", out_block, e.blk);
                        chk("sb_last", 64'(out_last), 64'(e.last));
                        chk("sb_nbytes", 64'(out_nbytes), 64'(e.nb));
                    end
                    hs_count++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  d;
        logic [63:0] eb;

        vt[0] = '{8, 8'h01, 8'h01, 1'b0, 64'h0102030405060708, 4'd8};
        vt[1] = '{3, 8'hAA, 8'h11, 1'b1, 64'hAABBCCFFFFFFFFFF, 4'd3};
        vt[2] = '{1, 8'h11, 8'h00, 1'b1, 64'h11FFFFFFFFFFFFFF, 4'd1};
        vt[3] = '{8, 8'h00, 8'h00, 1'b0, 64'h0000000000000000, 4'd8};
        vt[4] = '{8, 8'h21, 8'h01, 1'b1, 64'h2122232425262728, 4'd8};
        vt[5] = '{5, 8'h30, 8'h01, 1'b1, 64'h3031323334FFFFFF, 4'd5};
        vt[6] = '{7, 8'h40, 8'h01, 1'b1, 64'h40414243444546FF, 4'd7};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_block", out_block, 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_out_nbytes", 64'(out_nbytes), 64'd0);
        chk("rst_blk_count", 64'(blk_count), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-byte image on the PAD_BYTE=5A instance
        p_in_valid = 1'b1;
        p_in_data  = 8'h7E;
        p_in_last  = 1'b1;
        @(negedge clk);
        chk("pad_in_ready", 64'(p_in_ready), 64'd1);
        @(posedge clk);
        #1;
        p_in_valid = 1'b0;
        p_in_last  = 1'b0;
        chk("pad_out_valid", 64'(p_out_valid), 64'd1);
        chk("pad_out_block", p_out_block, 64'h7E5A5A5A5A5A5A5A);
        chk("pad_out_nbytes", 64'(p_out_nbytes), 64'd1);
        chk("pad_out_last", 64'(p_out_last), 64'd1);
        @(posedge clk);
        #1;
        chk("pad_blk_count", 64'(p_blk_count), 64'd1);
        chk("pad_out_valid_drop", 64'(p_out_valid), 64'd0);

        // Vector table, back-to-back with out_ready=1
        out_ready = 1'b1;
        for (int v = 0; v < 7; v++) begin
            push_exp(vt[v].blk, vt[v].last, vt[v].nb);
            d = vt[v].start;
            for (int i = 0; i < vt[v].n; i++) begin
                send_byte(d, vt[v].last && (i == vt[v].n - 1));
                d = d + vt[v].step;
            end
            chk("vec_latency_valid", 64'(out_valid), 64'd1);
            chk("vec_latency_block", out_block, vt[v].blk);
        end
        drain();
        chk("vec_blk_count", 64'(blk_count), 64'(blocks_sent));

        // Backpressure: 16 bytes with out_ready low for 20 cycles
        push_exp(64'h0001020304050607, 1'b0, 4'd8);
        push_exp(64'h08090A0B0C0D0E0F, 1'b0, 4'd8);
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0);
            end
            begin
                repeat (12) @(negedge clk);
                chk("bp_in_ready_low", 64'(in_ready), 64'd0);
                chk("bp_out_valid", 64'(out_valid), 64'd1);
                chk("bp_block_held", out_block, 64'h0001020304050607);
                repeat (7) @(negedge clk);
                chk("bp_block_stable", out_block, 64'h0001020304050607);
                chk("bp_nbytes_stable", 64'(out_nbytes), 64'd8);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_blk_count", 64'(blk_count), 64'(blocks_sent));

        // Streaming: 64 bytes, one block every 8 cycles
        for (int b = 0; b < 8; b++) begin
            eb = '0;
            for (int j = 0; j < 8; j++) eb = {eb[55:0], 8'(8'h80 + 8 * b + j)};
            push_exp(eb, 1'b0, 4'd8);
        end
        stream_mon = 1'b1;
        for (int i = 0; i < 64; i++) send_byte(8'(8'h80 + i), 1'b0);
        @(negedge clk);
        #1;
        stream_mon = 1'b0;
        chk("stream_ov_pulses", 64'(s_ov_cnt), 64'd8);
        chk("stream_ov_spacing_err", 64'(s_gap_err), 64'd0);
        chk("stream_in_ready_low", 64'(s_ir_low), 64'd0);
        drain();
        chk("stream_blk_count", 64'(blk_count), 64'(blocks_sent));

        // Reset mid-block after 5 accepted bytes
        for (int i = 0; i < 5; i++) send_byte(8'(8'h50 + i), 1'b0);
        #3;
        rst_n = 1'b0;
        #2;
        chk("mrst_in_ready", 64'(in_ready), 64'd0);
        chk("mrst_out_valid", 64'(out_valid), 64'd0);
        chk("mrst_out_block", out_block, 64'd0);
        chk("mrst_out_last", 64'(out_last), 64'd0);
        chk("mrst_out_nbytes", 64'(out_nbytes), 64'd0);
        chk("mrst_blk_count", 64'(blk_count), 64'd0);
        @(posedge clk);
        #4;
        rst_n = 1'b1;
        sbq.delete();
        blocks_sent = 0;
        @(posedge clk);
        #1;
        push_exp(64'h2122232425262728, 1'b0, 4'd8);
        for (int i = 0; i < 8; i++) send_byte(8'(8'h21 + i), 1'b0);
        chk("mrst_first_block", out_block, 64'h2122232425262728);
        drain();
        chk("mrst_blk_count", 64'(blk_count), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
